a1_485_resp_tx: RTL and testbench

//  RS-485 response transmitter for the A1 command link: the send side of the half-duplex

---
 rtl/a1_485_resp_tx_if.sv | 24 ++
 rtl/a1_485_resp_tx.sv | 189 ++++++++++++++++++
 tb/tb_a1_485_resp_tx.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/a1_485_resp_tx_if.sv
// Host-side bundle for the A1 RS-485 response transmitter: buffer writes,
// frame start and the transceiver/serial outputs.
interface a1_485_resp_tx_if;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [4:0] tx_len;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       f_de;
  logic       f_re;
  logic       txd;

  modport master (
    output wr_en, wr_addr, wr_data, tx_len, tx_start,
    input  tx_busy, tx_done, f_de, f_re, txd
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, tx_len, tx_start,
    output tx_busy, tx_done, f_de, f_re, txd
  );
endinterface

// File: rtl/a1_485_resp_tx.sv
// RS-485 response transmitter: sends up to 16 buffered bytes as 8N1 UART frames,
// optionally followed by an XOR checksum, framed by driver-enable guard times.
module a1_485_resp_tx #(
  parameter int unsigned CLK_DIV    = 96,
  parameter int unsigned GUARD_BITS = 1,
  parameter bit          ADD_CHK    = 1'b1
) (
  input  logic            clk_96M,
  input  logic            rst,
  a1_485_resp_tx_if.slave bus
);
  localparam int unsigned BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LEAD, S_START, S_DATA, S_STOP, S_TRAIL
  } state_t;

  state_t        r_state;
  logic [BW-1:0] r_baud;
  logic [15:0]   r_bit;
  logic [4:0]    r_idx;
  logic [4:0]    r_len;
  logic [4:0]    r_total;
  logic [7:0]    r_chk;
  logic [7:0]    r_shift;
  logic          r_txd;
  logic          r_de;
  logic          r_busy;
  logic          r_done;
  logic [7:0]    r_mem [16];

  logic       w_tick;
  logic       w_guard_last;
  logic       w_more;
  logic       w_load;
  logic       w_is_pay;
  logic [7:0] w_next_byte;
  logic [4:0] w_len_clamp;

  assign w_tick       = (r_baud == BW'(CLK_DIV - 1));
  assign w_guard_last = (r_bit == 16'(GUARD_BITS - 1));
  assign w_more       = (r_idx < r_total);
  assign w_len_clamp  = (bus.tx_len > 5'd16) ? 5'd16 : bus.tx_len;

  // Next byte to serialise: payload from the buffer, then the running checksum.
  always_comb begin
    if (r_idx < r_len) begin
      w_next_byte = r_mem[r_idx[3:0]];
      w_is_pay    = 1'b1;
    end else begin
      w_next_byte = r_chk;
      w_is_pay    = 1'b0;
    end
  end

  always_comb begin
    w_load = 1'b0;
    case (r_state)
      S_LOAD:  w_load = (GUARD_BITS == 0);
      S_LEAD:  w_load = w_tick && w_guard_last;
      S_STOP:  w_load = w_tick && w_more;
      default: w_load = 1'b0;
    endcase
  end

  // Buffer is frozen while a frame is in flight.
  always_ff @(posedge clk_96M) begin
    if (bus.wr_en && !r_busy) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk_96M) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= 16'd0;
      r_idx   <= 5'd0;
      r_len   <= 5'd0;
      r_total <= 5'd0;
      r_chk   <= 8'd0;
      r_shift <= 8'd0;
      r_txd   <= 1'b1;
      r_de    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE || r_state == S_LOAD) begin
        r_baud <= '0;
      end else begin
        r_baud <= w_tick ? '0 : r_baud + BW'(1);
      end

      case (r_state)
        S_IDLE: begin
          r_bit <= 16'd0;
          if (bus.tx_start) begin
            if (bus.tx_len == 5'd0) begin
              r_done <= 1'b1;
            end else begin
              r_len   <= w_len_clamp;
              r_total <= w_len_clamp + 5'(ADD_CHK);
              r_idx   <= 5'd0;
              r_chk   <= 8'd0;
              r_de    <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= S_LOAD;
            end
          end
        end
        // One settling cycle so a write in the start cycle reaches the first byte.
        S_LOAD: begin
          if (GUARD_BITS != 0) begin
            r_state <= S_LEAD;
          end
        end
        S_LEAD: begin
          if (w_tick) begin
            r_bit <= r_bit + 16'd1;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_txd   <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_bit   <= 16'd0;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_bit == 16'd7) begin
              r_txd   <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_txd   <= r_shift[0];
              r_shift <= r_shift >> 1;
              r_bit   <= r_bit + 16'd1;
            end
          end
        end
        S_STOP: begin
          if (w_tick && !w_more) begin
            if (GUARD_BITS != 0) begin
              r_bit   <= 16'd0;
              r_state <= S_TRAIL;
            end else begin
              r_de    <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        S_TRAIL: begin
          if (w_tick) begin
            if (w_guard_last) begin
              r_de    <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_bit <= r_bit + 16'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Entering a start bit always loads the next byte; checksum covers payload only.
      if (w_load) begin
        r_shift <= w_next_byte;
        r_idx   <= r_idx + 5'd1;
        r_txd   <= 1'b0;
        r_state <= S_START;
        if (w_is_pay) begin
          r_chk <= r_chk ^ w_next_byte;
        end
      end
    end
  end

  assign bus.tx_busy = r_busy;
  assign bus.tx_done = r_done;
  assign bus.f_de    = r_de;
  assign bus.f_re    = r_de;
  assign bus.txd     = r_txd;
endmodule

// File: tb/tb_a1_485_resp_tx.sv
// Self-checking bench: three parameterisations of the transmitter compared cycle by
// cycle against a waveform model derived from the frame timing rules.
module tb_a1_485_resp_tx;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  a1_485_resp_tx_if ifa ();
  a1_485_resp_tx_if ifb ();
  a1_485_resp_tx_if ifc ();

  logic       t_wr_en, t_tx_start;
  logic [3:0] t_wr_addr;
  logic [7:0] t_wr_data;
  logic [4:0] t_tx_len;
  int         sel;

  assign ifa.wr_en = t_wr_en && (sel == 0);
  assign ifb.wr_en = t_wr_en && (sel == 1);
  assign ifc.wr_en = t_wr_en && (sel == 2);
  assign ifa.tx_start = t_tx_start && (sel == 0);
  assign ifb.tx_start = t_tx_start && (sel == 1);
  assign ifc.tx_start = t_tx_start && (sel == 2);
  assign ifa.wr_addr = t_wr_addr;
  assign ifb.wr_addr = t_wr_addr;
  assign ifc.wr_addr = t_wr_addr;
  assign ifa.wr_data = t_wr_data;
  assign ifb.wr_data = t_wr_data;
  assign ifc.wr_data = t_wr_data;
  assign ifa.tx_len = t_tx_len;
  assign ifb.tx_len = t_tx_len;
  assign ifc.tx_len = t_tx_len;

  a1_485_resp_tx #(.CLK_DIV(96), .GUARD_BITS(1), .ADD_CHK(1'b1)) dut_a (.clk_96M(clk), .rst(rst), .bus(ifa.slave));
  a1_485_resp_tx #(.CLK_DIV(8),  .GUARD_BITS(1), .ADD_CHK(1'b0)) dut_b (.clk_96M(clk), .rst(rst), .bus(ifb.slave));
  a1_485_resp_tx #(.CLK_DIV(4),  .GUARD_BITS(0), .ADD_CHK(1'b1)) dut_c (.clk_96M(clk), .rst(rst), .bus(ifc.slave));

  // Observed bus of the selected unit: {f_de, f_re, tx_busy, tx_done, txd}
  logic [4:0] obs;
  always_comb begin
    case (sel)
      0:       obs = {ifa.f_de, ifa.f_re, ifa.tx_busy, ifa.tx_done, ifa.txd};
      1:       obs = {ifb.f_de, ifb.f_re, ifb.tx_busy, ifb.tx_done, ifb.txd};
      default: obs = {ifc.f_de, ifc.f_re, ifc.tx_busy, ifc.tx_done, ifc.txd};
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;
  int last_de_cnt;
  logic [7:0] sh [3][16];
  logic [7:0] m_bytes [$];
  bit   m_empty;
  int   m_d, m_g;
  logic [7:0] inj_data;

  function automatic int d_of(input int s);
    return (s == 0) ? 96 : ((s == 1) ? 8 : 4);
  endfunction
  function automatic int g_of(input int s);
    return (s == 2) ? 0 : 1;
  endfunction
  function automatic bit c_of(input int s);
    return (s != 1);
  endfunction

  // Expected bus k cycles after the accepting edge, from the frame timing rules.
  function automatic logic [4:0] exp_bus(input int k);
    int nb, len, j, p;
    logic [7:0] b;
    logic de, dn, td;
    if (m_empty) return {1'b0, 1'b0, 1'b0, (k == 0), 1'b1};
    nb  = m_bytes.size();
    len = 1 + m_d * (2 * m_g + 10 * nb);
    de  = (k < len);
    dn  = (k == len);
    td  = 1'b1;
    j   = k - 1 - m_g * m_d;
    if (j >= 0 && j < 10 * nb * m_d) begin
      p = (j % (10 * m_d)) / m_d;
      b = m_bytes[j / (10 * m_d)];
      if (p == 0) td = 1'b0;
      else if (p <= 8) td = b[p-1];
    end
    return {de, de, de, dn, td};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check5(input string tag, input int k, input logic [4:0] o, input logic [4:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, o, e);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    t_wr_en   = 1'b1;
    t_wr_addr = a[3:0];
    t_wr_data = d;
    tick();
    t_wr_en   = 1'b0;
    sh[sel][a] = d;
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n && i < 16; i++) wr(i, 8'($urandom_range(0, 255)));
  endtask

  // inj: 0 none, 1 start+write mid-frame, 2 reset at inj_k, 3 write addr 0 in start cycle
  task automatic run_frame(input string tag, input int n_req, input int inj, input int inj_k);
    int n, len, de_cnt, f0, w;
    logic [7:0] x;
    bit seen;
    n = (n_req > 16) ? 16 : n_req;
    if (inj == 3) sh[sel][0] = inj_data;
    m_bytes.delete();
    x = 8'd0;
    for (int i = 0; i < n; i++) begin
      m_bytes.push_back(sh[sel][i]);
      x = x ^ sh[sel][i];
    end
    if (n > 0 && c_of(sel)) m_bytes.push_back(x);
    m_empty = (n == 0);
    m_d = d_of(sel);
    m_g = g_of(sel);
    len = m_empty ? 1 : 1 + m_d * (2 * m_g + 10 * m_bytes.size());
    check5({tag, "_pre"}, -1, obs, 5'b00001);
    t_tx_len   = n_req[4:0];
    t_tx_start = 1'b1;
    if (inj == 3) begin
      t_wr_en = 1'b1; t_wr_addr = 4'd0; t_wr_data = inj_data;
    end
    tick();
    t_tx_start = 1'b0;
    t_wr_en    = 1'b0;
    de_cnt = 0;
    for (int k = 0; k <= len + 1; k++) begin
      if (k > 0) tick();
      if (inj == 2 && k == inj_k + 1) begin
        rst = 1'b0;
        check5({tag, "_rst"}, k, obs, 5'b00001);
        seen = 1'b0;
        for (w = 0; w < len; w++) begin
          tick();
          if (obs !== 5'b00001) seen = 1'b1;
        end
        check_int({tag, "_no_done_after_rst"}, int'(seen), 0);
        last_de_cnt = de_cnt;
        return;
      end
      f0 = n_fail;
      check5(tag, k, obs, exp_bus(k));
      if (n_fail != f0) break;
      if (obs[4]) de_cnt++;
      if (inj == 1 && k == inj_k) begin
        t_tx_start = 1'b1; t_wr_en = 1'b1; t_wr_addr = 4'd0; t_wr_data = 8'hAA; t_tx_len = 5'd16;
      end
      if (inj == 1 && k == inj_k + 1) begin
        t_tx_start = 1'b0; t_wr_en = 1'b0;
      end
      if (inj == 2 && k == inj_k) rst = 1'b1;
    end
    last_de_cnt = de_cnt;
  endtask

  initial begin
    rst = 1'b1;
    t_wr_en = 1'b0; t_tx_start = 1'b0; t_wr_addr = 4'd0; t_wr_data = 8'd0; t_tx_len = 5'd0;
    sel = 0;
    inj_data = 8'd0;
    tick(); tick(); tick();
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check5("reset_idle", s, obs, 5'b00001);
    end

    // Two-byte response with checksum at 1 Mbaud
    sel = 0;
    wr(0, 8'h2E);
    wr(1, 8'h55);
    run_frame("t1_2e55", 2, 0, 0);
    check_int("t1_de_cycles", last_de_cnt, 3073);

    // Empty response: only a done pulse
    run_frame("t2_len0_a", 0, 0, 0);
    sel = 2;
    run_frame("t2_len0_c", 0, 0, 0);

    // Full 16-byte buffer without checksum, then an over-length request
    sel = 1;
    for (int i = 0; i < 16; i++) wr(i, 8'(i));
    run_frame("t3_len16", 16, 0, 0);
    check_int("t3_de_cycles", last_de_cnt, 1 + 8 * (2 + 160));
    fill_rand(16);
    run_frame("t3_clamp", 5'($urandom_range(17, 31)), 0, 0);

    // Start and write while busy are ignored
    fill_rand(2);
    run_frame("t4_busy_ign", 2, 1, 40);
    run_frame("t4_after", 1, 0, 0);

    // Reset during data bits of the second byte, then a clean frame
    sel = 2;
    fill_rand(3);
    run_frame("t5_abort", 3, 2, 1 + 40 + 12);
    run_frame("t5_rerun", 3, 0, 0);

    // Zero guard time, single byte
    wr(0, 8'h81);
    run_frame("t6_g0", 1, 0, 0);
    check_int("t6_de_cycles", last_de_cnt, 1 + 4 * 20);

    // Write coinciding with the start pulse lands in the frame
    wr(1, 8'($urandom_range(0, 255)));
    inj_data = 8'($urandom_range(0, 255));
    run_frame("same_cycle_wr", 2, 3, 0);

    // Randomised frames
    for (int r = 0; r < 8; r++) begin
      int ln;
      ln = $urandom_range(0, 20);
      fill_rand(ln);
      run_frame("rand_c", ln, 0, 0);
    end
    sel = 1;
    for (int r = 0; r < 3; r++) begin
      int ln;
      ln = $urandom_range(1, 16);
      fill_rand(ln);
      run_frame("rand_b", ln, 0, 0);
    end
    sel = 0;
    fill_rand(1);
    run_frame("rand_a", 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
